branch_resolve_unit: RTL

- EX-stage counterpart of the branch target buffer: consumes the BTB query result produced in IF and drives the BTB update port.
- Carries each fetch's prediction metadata (pc, hit, br, pred) down a two-entry shadow pipeline (IF/ID, ID/EX) in lockstep with the core.
- At EX, compares the prediction with the actual branch outcome. Generates the BTB write (update, BR, PC_update, update_data), a front-end redirect on misprediction, and branch/mispredict performance counters.

---
 rtl/branch_resolve_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// EX-stage partner of the branch target buffer. The BTB answer given in IF
// (hit, br, predicted PC) travels with its fetch through a two-entry shadow
// pipeline (IF/ID, ID/EX). In EX the prediction is compared with the real
// branch outcome. The unit then drives the BTB write port, a front-end
// redirect on a misprediction, and two saturating performance counters.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall_id / flush_id       hold / invalidate the IF/ID metadata entry
//   stall_ex / flush_ex       hold / invalidate the ID/EX metadata entry
//                             (stall_ex also suppresses all EX outputs)
//   if_pc, if_btb_hit,
//   if_btb_br, if_pc_pred     BTB query result for the instruction in IF
//   ex_is_br, ex_taken,
//   ex_target                 resolved branch information in EX
//   btb_update, btb_br,
//   btb_update_pc,
//   btb_update_data           BTB write port (combinational in EX)
//   redirect, redirect_pc     mispredict redirect (combinational in EX)
//   br_count, miss_count      saturating branch / mispredict counters
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_id,
    input  logic             stall_ex,
    input  logic             flush_id,
    input  logic             flush_ex,
    input  logic [31:0]      if_pc,
    input  logic             if_btb_hit,
    input  logic             if_btb_br,
    input  logic [31:0]      if_pc_pred,
    input  logic             ex_is_br,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             btb_update,
    output logic             btb_br,
    output logic [31:0]      btb_update_pc,
    output logic [31:0]      btb_update_data,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    // Saturating increment: the counters stick at all-ones and never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == {CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + CNT_W'(1);
        end
        return res;
    endfunction

    // IF/ID metadata entry
    logic        ifid_v_r;
    logic [31:0] ifid_pc_r;
    logic        ifid_hit_r;
    logic        ifid_br_r;
    logic [31:0] ifid_pred_r;

    // ID/EX metadata entry
    logic        idex_v_r;
    logic [31:0] idex_pc_r;
    logic        idex_hit_r;
    logic        idex_br_r;
    logic [31:0] idex_pred_r;

    // EX evaluation
    logic        act_s;
    logic        pred_taken_s;
    logic        actual_taken_s;
    logic        mispredict_s;
    logic [31:0] fallthru_s;
    logic [31:0] fix_pc_s;

    // Performance counters
    logic [CNT_W-1:0] br_cnt_r;
    logic [CNT_W-1:0] miss_cnt_r;

    // IF/ID register: flush (external or self on redirect) beats stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_v_r    <= 1'b0;
            ifid_pc_r   <= 32'd0;
            ifid_hit_r  <= 1'b0;
            ifid_br_r   <= 1'b0;
            ifid_pred_r <= 32'd0;
        end else if (flush_id || redirect) begin
            ifid_v_r    <= 1'b0;
        end else if (stall_id) begin
            ifid_v_r    <= ifid_v_r;
        end else begin
            ifid_v_r    <= 1'b1;
            ifid_pc_r   <= if_pc;
            ifid_hit_r  <= if_btb_hit;
            ifid_br_r   <= if_btb_br;
            ifid_pred_r <= if_pc_pred;
        end
    end

    // ID/EX register: flush beats stall; a stalled ID hands EX a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_v_r    <= 1'b0;
            idex_pc_r   <= 32'd0;
            idex_hit_r  <= 1'b0;
            idex_br_r   <= 1'b0;
            idex_pred_r <= 32'd0;
        end else if (flush_ex || redirect) begin
            idex_v_r    <= 1'b0;
        end else if (stall_ex) begin
            idex_v_r    <= idex_v_r;
        end else if (stall_id) begin
            idex_v_r    <= 1'b0;
        end else begin
            idex_v_r    <= ifid_v_r;
            idex_pc_r   <= ifid_pc_r;
            idex_hit_r  <= ifid_hit_r;
            idex_br_r   <= ifid_br_r;
            idex_pred_r <= ifid_pred_r;
        end
    end

    // Compare prediction with outcome and drive BTB write and redirect.
    always_comb begin
        act_s          = idex_v_r & ~stall_ex;
        pred_taken_s   = idex_hit_r & idex_br_r;
        actual_taken_s = ex_is_br & ex_taken;
        fallthru_s     = idex_pc_r + 32'd4;

        // A non-branch that the BTB calls taken is a stale or aliased entry.
        if (ex_is_br) begin
            mispredict_s = (ex_taken != pred_taken_s) |
                           (ex_taken & pred_taken_s & (ex_target != idex_pred_r));
        end else begin
            mispredict_s = pred_taken_s;
        end

        // The corrected fetch PC is also the data written back to the BTB.
        if (actual_taken_s) begin
            fix_pc_s = ex_target;
        end else begin
            fix_pc_s = fallthru_s;
        end

        redirect        = 1'b0;
        redirect_pc     = 32'd0;
        btb_update      = 1'b0;
        btb_br          = 1'b0;
        btb_update_pc   = 32'd0;
        btb_update_data = 32'd0;

        if (act_s) begin
            redirect   = mispredict_s;
            // Branches missing the BTB allocate; correct hits never rewrite.
            btb_update = mispredict_s | (ex_is_br & ~idex_hit_r);
        end else begin
            redirect   = 1'b0;
            btb_update = 1'b0;
        end

        if (redirect) begin
            redirect_pc = fix_pc_s;
        end else begin
            redirect_pc = 32'd0;
        end

        if (btb_update) begin
            btb_br          = actual_taken_s;
            btb_update_pc   = idex_pc_r;
            btb_update_data = fix_pc_s;
        end else begin
            btb_br          = 1'b0;
            btb_update_pc   = 32'd0;
            btb_update_data = 32'd0;
        end
    end

    // Saturating branch and mispredict counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_r   <= {CNT_W{1'b0}};
            miss_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (act_s && ex_is_br) begin
                br_cnt_r <= sat_inc(br_cnt_r);
            end else begin
                br_cnt_r <= br_cnt_r;
            end
            if (redirect) begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
        end
    end

    assign br_count   = br_cnt_r;
    assign miss_count = miss_cnt_r;

endmodule
